// File: rtl/data_mem_unit_if.sv
// data_mem_unit_if
// Bundles the core <-> data-memory signals of the single-cycle MIPS core.
//   mem_read, mem_write : load / store requests from the control unit
//   addr                : byte address (ALU result)
//   wdata               : store data (register-file ReadData2)
//   rdata               : load data to the write-back mux, valid while ready=1
//   ready               : one-cycle pulse when a load completes
//   stall               : hold PC and the current instruction
//   misalign_err        : sticky flag, set by any misaligned request
// Modports: master = core side, slave = memory side.
interface data_mem_unit_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        stall;
    logic        misalign_err;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, ready, stall, misalign_err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, ready, stall, misalign_err
    );
endinterface

// File: rtl/data_mem_unit.sv
// data_mem_unit
// Data-memory stage of the single-cycle MIPS core. Stores complete in one
// edge; loads take READ_LAT edges after acceptance and hold the core via
// stall until the data is presented with a one-cycle ready pulse.
// Misaligned requests are dropped and recorded in a sticky error flag.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; clears all control state
//   bus   : data_mem_unit_if slave modport (requests in, load data/status out)
// Parameters:
//   DEPTH    : number of 32-bit words (power of two)
//   READ_LAT : load latency in edges after acceptance (1..15)
module data_mem_unit #(
    parameter int DEPTH    = 256,
    parameter int READ_LAT = 2
) (
    input  logic            clk,
    input  logic            reset,
    data_mem_unit_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

    logic [1:0]       state;
    logic [3:0]       cnt;
    logic [IDX_W-1:0] load_idx;
    logic [31:0]      load_data;
    logic             err_flag;

    logic [31:0]      mem [DEPTH];

    logic             aligned;
    logic [IDX_W-1:0] addr_idx;
    logic             store_en;
    logic             unused_addr;

    // Upper address bits alias; only the word index within DEPTH matters.
    assign aligned     = (bus.addr[1:0] == 2'b00);
    assign addr_idx    = bus.addr[IDX_W+1:2];
    assign unused_addr = ^bus.addr[31:IDX_W+2];

    // Stores only land from IDLE; gated by reset so a store presented while
    // reset is held cannot corrupt the array.
    assign store_en = (state == S_IDLE) && bus.mem_write && aligned && !reset;

    always_ff @(posedge clk) begin
        if (store_en) begin
            mem[addr_idx] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            load_idx  <= '0;
            load_data <= 32'd0;
            err_flag  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.mem_write || bus.mem_read) begin
                        if (!aligned) begin
                            err_flag <= 1'b1;
                        end else if (!bus.mem_write) begin
                            // Write has priority; only a pure read starts a load.
                            load_idx <= addr_idx;
                            cnt      <= LAT_M1;
                            state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        load_data <= mem[load_idx];
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    // Requests seen here belong to the instruction being retired.
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Stall covers the request cycle itself plus every WAIT cycle.
    assign bus.stall = ((state == S_IDLE) && bus.mem_read && !bus.mem_write && aligned)
                     || (state == S_WAIT);
    assign bus.ready        = (state == S_DONE);
    assign bus.rdata        = load_data;
    assign bus.misalign_err = err_flag;

endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit
// Directed bench for data_mem_unit with a cycle-level reference model.
// The model tracks memory contents in an associative array and describes a
// load purely by its acceptance cycle: stalled until READ_LAT cycles after
// acceptance, ready in the cycle after that. Directed tasks add literal checks.
module tb_data_mem_unit;

    localparam int DEPTH = 256;
    localparam int RL    = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    data_mem_unit_if bus();

    data_mem_unit #(.DEPTH(DEPTH), .READ_LAT(RL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem [int];
    bit          m_busy;
    int          m_t0;
    logic [31:0] m_data;
    logic [31:0] m_rdata;
    bit          m_err;
    bit          m_in_wait, m_in_done, m_idle, m_alg;
    logic [31:0] m_word;

    function automatic int widx(input logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        return int'(w % 32'(DEPTH));
    endfunction

    function automatic logic [31:0] mread(input int k);
        if (m_mem.exists(k)) return m_mem[k];
        return 32'hxxxxxxxx;
    endfunction

    initial begin
        m_busy  = 0;
        m_t0    = 0;
        m_data  = 32'd0;
        m_rdata = 32'd0;
        m_err   = 0;
    end

    // Inputs change only just after a rising edge, so at the falling edge they
    // are the values the next rising edge will act on.
    always @(negedge clk) begin
        if (reset) begin
            m_busy  = 0;
            m_rdata = 32'd0;
            m_err   = 0;
        end
        m_alg     = (bus.addr[1:0] == 2'b00);
        m_in_wait = m_busy && (cyc < m_t0 + RL);
        m_in_done = m_busy && (cyc == m_t0 + RL);
        m_idle    = !m_in_wait && !m_in_done;
        if (m_in_done) m_rdata = m_data;

        check("stall", 32'(bus.stall),
              32'(m_in_wait || (m_idle && bus.mem_read && !bus.mem_write && m_alg)));
        check("ready", 32'(bus.ready), 32'(m_in_done));
        check("rdata", bus.rdata, m_rdata);
        check("misalign_err", 32'(bus.misalign_err), 32'(m_err));

        if (!reset) begin
            if (m_in_done) m_busy = 0;
            if (m_idle && (bus.mem_write || bus.mem_read)) begin
                if (!m_alg) begin
                    m_err = 1;
                end else if (bus.mem_write) begin
                    m_mem[widx(bus.addr)] = bus.wdata;
                end else begin
                    m_busy = 1;
                    m_t0   = cyc + 1;
                    m_data = mread(widx(bus.addr));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.addr      = a;
        bus.wdata     = d;
        bus.mem_write = 1'b1;
        @(posedge clk);
        #1 bus.mem_write = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, output logic [31:0] data,
                           output int stalls, output int rcyc);
        bit got;
        got    = 0;
        stalls = 0;
        rcyc   = -1;
        data   = 32'hxxxxxxxx;
        bus.addr     = a;
        bus.mem_read = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                got  = 1;
                data = bus.rdata;
                rcyc = cyc;
            end else if (bus.stall) begin
                stalls++;
            end
        end
        check("load_completes", 32'(got), 32'd1);
        @(posedge clk);
        #1 bus.mem_read = 1'b0;
    endtask

    logic [31:0] d1, d2;
    int          s1, s2, r1, r2, pulses;

    initial begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.addr      = 32'd0;
        bus.wdata     = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_rdata", bus.rdata, 32'd0);
        check("reset_ready", 32'(bus.ready), 32'd0);
        check("reset_err", 32'(bus.misalign_err), 32'd0);

        // Store then load
        store(32'h10, 32'hDEADBEEF);
        do_load(32'h10, d1, s1, r1);
        check("load10_data", d1, 32'hDEADBEEF);
        check("load10_stalls", 32'(s1), 32'(RL + 1));
        @(negedge clk);
        check("after_done_stall", 32'(bus.stall), 32'd0);

        // Aliasing
        store(32'h400, 32'h12345678);
        do_load(32'h000, d1, s1, r1);
        check("alias_400_to_0", d1, 32'h12345678);
        store(32'h3FC, 32'h55AA55AA);
        do_load(32'h000, d1, s1, r1);
        check("word0_after_3fc", d1, 32'h12345678);
        do_load(32'h3FC, d1, s1, r1);
        check("load_3fc", d1, 32'h55AA55AA);

        // Misaligned store
        store(32'h20, 32'hA5A5A5A5);
        store(32'h21, 32'hFFFFFFFF);
        check("err_after_mis_store", 32'(bus.misalign_err), 32'd1);
        do_load(32'h20, d1, s1, r1);
        check("word20_unchanged", d1, 32'hA5A5A5A5);

        // Mid-cycle asynchronous reset: outputs clear without an edge
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_rdata", bus.rdata, 32'd0);
        check("async_rst_err", 32'(bus.misalign_err), 32'd0);
        check("async_rst_ready", 32'(bus.ready), 32'd0);
        check("async_rst_stall", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Misaligned load never stalls, but sets the flag
        bus.addr     = 32'h22;
        bus.mem_read = 1'b1;
        @(negedge clk);
        check("mis_load_stall", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1 bus.mem_read = 1'b0;
        check("err_after_mis_load", 32'(bus.misalign_err), 32'd1);

        // Simultaneous read+write: the write wins, no stall
        store(32'h34, 32'h0BAD0034);
        bus.addr      = 32'h30;
        bus.wdata     = 32'hCAFE0030;
        bus.mem_write = 1'b1;
        bus.mem_read  = 1'b1;
        @(negedge clk);
        check("rw_stall", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1;
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b0;
        @(negedge clk);
        check("rw_no_ready", 32'(bus.ready), 32'd0);

        // Back-to-back loads
        @(posedge clk);
        #1;
        do_load(32'h30, d1, s1, r1);
        do_load(32'h34, d2, s2, r2);
        check("b2b_first", d1, 32'hCAFE0030);
        check("b2b_second", d2, 32'h0BAD0034);
        check("b2b_spacing", 32'(r2 - r1), 32'(RL + 2));

        // Reset in the second WAIT cycle
        bus.addr     = 32'h10;
        bus.mem_read = 1'b1;
        @(posedge clk);   // acceptance edge
        @(posedge clk);   // now in the second WAIT cycle
        #2;
        reset        = 1'b1;
        bus.mem_read = 1'b0;
        #1;
        check("wait_rst_stall", 32'(bus.stall), 32'd0);
        check("wait_rst_ready", 32'(bus.ready), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.ready) pulses++;
        end
        check("wait_rst_no_ready", 32'(pulses), 32'd0);
        @(posedge clk);
        #1;
        do_load(32'h10, d1, s1, r1);
        check("mem_kept_after_rst", d1, 32'hDEADBEEF);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Data-memory stage for the single-cycle MIPS core. It sits directly downstream of the ALU: it consumes the ALU result as a byte address, register-file read port 2 as store data, and the control unit's MemWrite/MemRead. It returns load data to the write-back mux. Stores complete in one cycle. Loads take a parameterised multi-cycle latency, and the block raises `stall` to freeze the PC while a load is outstanding. Misaligned accesses are suppressed and recorded in a sticky flag.

## Interface
- `DEPTH`, 256: number of 32-bit words; must be a power of two. `IDX_W = clog2(DEPTH)`.
- `READ_LAT`, 2: load latency in clock edges after acceptance; legal range 1..15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all control state immediately.
- `mem_read`  in  1  load request from the control unit.
- `mem_write`  in  1  store request from the control unit.
- `addr`  in  32  byte address (ALU result).
- `wdata`  in  32  store data (register-file ReadData2).
- `rdata`  out  32  load data to the write-back mux; valid while `ready`=1.
- `ready`  out  1  high for exactly one cycle when `rdata` holds the completed load.
- `stall`  out  1  combinational; high while the core must hold PC and the current instruction.
- `misalign_err`  out  1  sticky; set by any misaligned request.

## Operation
- Word index is `addr[IDX_W+1:2]`. Upper address bits are ignored, so addresses alias modulo `DEPTH*4`.
- An address is aligned iff `addr[1:0]==0`.
- FSM states:
  - IDLE: accepts requests.
  - WAIT: counts down the load latency.
  - DONE: presents load data for one cycle.
- IDLE, `mem_write`=1:
  - If aligned, the addressed word is written with `wdata` at the edge.
  - State stays IDLE; no stall; `ready` stays 0.
  - `mem_write` has priority: if `mem_read` is also 1, the read is ignored.
- IDLE, `mem_read`=1 (and `mem_write`=0), aligned:
  - At the edge, latch the index, load `cnt` with READ_LAT-1, and go to WAIT.
- IDLE, misaligned read or write:
  - No memory access; state stays IDLE; `misalign_err` set to 1 at the edge; no stall.
- WAIT, at each edge:
  - If `cnt`==0: `rdata` is loaded with the memory word at the latched index, and the state goes to DONE.
  - Otherwise `cnt` decrements.
- DONE:
  - `ready`=1 and `stall`=0, so the core commits the load at this edge.
  - Next edge goes to IDLE unconditionally.
  - Requests seen in DONE are ignored; they belong to the stalled instruction being retired.
- `mem_read` and `mem_write` during WAIT are ignored. Writes never modify memory outside IDLE.
- `stall` = (IDLE & `mem_read` & !`mem_write` & aligned) | WAIT.
- `rdata` holds its value until the next load completes.
- Memory array contents are not reset.

## Timing
- Reset values, asserted asynchronously: state IDLE, `cnt` 0, `rdata` 0, `ready` 0, `misalign_err` 0. `stall` is 0 as long as no aligned read is presented.
- Store latency: 1 edge. A load issued in the following cycle to the same word returns the new value.
- Load timeline, with acceptance edge t0:
  - Cycles in WAIT: READ_LAT.
  - DONE cycle: the cycle after edge t0+READ_LAT.
  - Stalled cycles: READ_LAT+1 (request cycle plus WAIT cycles).
  - Total cycles the instruction occupies: READ_LAT+2.
- Example, READ_LAT=1: request cycle (stall), 1 WAIT cycle (stall), DONE (ready).
- Back-to-back loads: the second load is accepted in the IDLE cycle after DONE; no cycle is lost beyond the single IDLE.
- Reset asserted mid-load (WAIT or DONE): the pending load is dropped, `ready` never pulses, and `stall` drops immediately.
- `misalign_err` is cleared only by reset.

## Test plan
- Reset: assert `reset` mid-cycle. All outputs go to 0 before the next edge, and no edge is required.
- Store then load, READ_LAT=2:
  - Store `0xDEADBEEF` to `addr` 0x10.
  - Load from 0x10: `stall`=1 for 3 cycles, then `ready`=1 for 1 cycle with `rdata`=`0xDEADBEEF`, then `stall`=0.
- Aliasing with DEPTH=256:
  - Store `0x12345678` to 0x400; load from 0x000 returns `0x12345678`.
  - Store to 0x3FC does not disturb word 0.
- Misaligned access:
  - Store `0xFFFFFFFF` to 0x21: the word at 0x20 is unchanged and `misalign_err`=1 from the next cycle.
  - Load from 0x22: `stall` never asserts.
- Simultaneous and back-to-back requests:
  - `mem_read`=`mem_write`=1 at 0x30: a write occurs and there is no stall.
  - Two consecutive loads to 0x30/0x34: the second `ready` pulse comes exactly READ_LAT+2 cycles after the first.
- Reset during WAIT: load issued, then `reset` pulsed in the 2nd WAIT cycle. `ready` never pulses, state returns to IDLE, and memory is preserved: a later load from 0x10 returns `0xDEADBEEF`.
